tiny_rr_merger: RTL

// - 2-to-1 merge of two valid/ready write streams (s1, s2) into one downstream port (m).
// - Reverse-direction companion to the address-decoding 1-to-2 splitter.
// - Merges traffic from two initiators onto one target; round-robin arbitration, registered output.
// - Output tags each beat with its source index (m_src).

---
 rtl/tiny_rr_merger.sv | 52 +++++
 1 files changed

// File: rtl/tiny_rr_merger.sv
// tiny_rr_merger: round-robin 2-to-1 merge of two valid/ready write streams into one registered output port.
module tiny_rr_merger #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [DATA_W-1:0] s1_data,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic              s2_valid,
    output logic              s2_ready,
    input  logic [DATA_W-1:0] s2_data,
    input  logic [ADDR_W-1:0] s2_addr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_src
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t r_state, w_state_nxt;
    logic   r_last_s2;
    logic   w_load_ok, w_load;
    // r_last_s2 set means s2 was granted last, so s1 wins the next contention
    always_comb begin
        w_load_ok   = (r_state == EMPTY) | m_ready;
        s1_ready    = w_load_ok & s1_valid & (~s2_valid | r_last_s2);
        s2_ready    = w_load_ok & s2_valid & (~s1_valid | ~r_last_s2);
        w_load      = s1_ready | s2_ready;
        w_state_nxt = w_load ? FULL : (m_ready ? EMPTY : r_state);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= EMPTY;
            r_last_s2 <= 1'b1;
            m_data    <= '0;
            m_addr    <= '0;
            m_src     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                m_data    <= s2_ready ? s2_data : s1_data;
                m_addr    <= s2_ready ? s2_addr : s1_addr;
                m_src     <= s2_ready;
                r_last_s2 <= s2_ready;
            end
        end
    end
    assign m_valid = (r_state == FULL);
endmodule
